sodor5_instr_stim_gen: RTL and testbench

- Synthesizable constrained-random instruction source that sits directly upstream of the sodor5 verification top and drives its `instr` input.
- Replaces the behavioural per-clock random generator, so formal and emulation runs get the same reproducible stream.
- Emits I-type ALU and, optionally, byte-load instructions from an LFSR, with a valid/ready handshake.
- Runs for a fixed instruction budget, then drains the 5-stage pipeline with NOPs and raises `done`.

---
 rtl/sodor5_stim_pkg.sv | 44 ++++
 rtl/sodor5_lfsr32.sv | 37 +++
 rtl/sodor5_instr_stim_gen.sv | 165 ++++++++++++++++
 tb/tb_sodor5_instr_stim_gen.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sodor5_stim_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sodor5_stim_pkg
// Description : Shared constants, state type and the instruction-word builder
//               for the sodor5 constrained-random instruction source.
// Revision    : 1.0 - initial release
// ============================================================================
package sodor5_stim_pkg;

    localparam logic [6:0]  OP_IMM    = 7'b0010011;
    localparam logic [6:0]  OP_LOAD   = 7'b0000011;
    localparam logic [31:0] NOP_INSTR = 32'h00000013;
    localparam logic [31:0] LFSR_MASK = 32'h80200003;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } stim_state_t;

    // Slices one LFSR state into an I-type ALU op or, when loads are enabled
    // and the low two bits are zero, a byte load (LB or LBU picked by bit 14).
    // Shift immediates are masked so SLLI/SRLI/SRAI stay legal encodings.
    function automatic logic [31:0] build_word(input logic [31:0] l,
                                               input logic        load_en);
        logic [11:0] imm_m;
        logic [31:0] word;
        imm_m = l[31:20];
        case (l[14:12])
            3'd5:    imm_m = l[31:20] & 12'h41F;
            3'd1:    imm_m = l[31:20] & 12'h01F;
            default: imm_m = l[31:20];
        endcase
        if (load_en && (l[1:0] == 2'b00)) begin
            word = {l[31:20], l[19:15], (l[14] ? 3'b100 : 3'b000), l[11:7], OP_LOAD};
        end else begin
            word = {imm_m, l[19:15], l[14:12], l[11:7], OP_IMM};
        end
        return word;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sodor5_lfsr32.sv
`default_nettype none
// ============================================================================
// Module      : sodor5_lfsr32
// Description : 32-bit Galois LFSR (x^32+x^22+x^2+x+1) with seed load and
//               advance controls; exposes current and next state.
//   clk        in   clock
//   load_seed  in   load `seed` into the register (highest priority)
//   advance    in   step the register to next_state
//   seed       in   32-bit seed value
//   state      out  current LFSR state
//   next_state out  combinational successor of `state`
// Revision    : 1.0 - initial release
// ============================================================================
module sodor5_lfsr32
    import sodor5_stim_pkg::*;
(
    input  logic        clk,
    input  logic        load_seed,
    input  logic        advance,
    input  logic [31:0] seed,
    output logic [31:0] state,
    output logic [31:0] next_state
);

    // Right-shifting Galois form: the bit shifted out selects the tap mask.
    assign next_state = {1'b0, state[31:1]} ^ (state[0] ? LFSR_MASK : 32'h0);

    always_ff @(posedge clk) begin
        if (load_seed) begin
            state <= seed;
        end else if (advance) begin
            state <= next_state;
        end
    end

endmodule
`default_nettype wire

// File: rtl/sodor5_instr_stim_gen.sv
`default_nettype none
// ============================================================================
// Module      : sodor5_instr_stim_gen
// Description : Synthesizable constrained-random instruction source for the
//               sodor5 verification top. Issues NUM_INSTRS LFSR-derived
//               instructions over a valid/ready handshake, then DRAIN_NOPS
//               NOPs, then raises done until reset.
//   clk          in   clock
//   reset        in   synchronous active-high reset
//   en           in   run enable (low pauses the offer)
//   instr_ready  in   consumer accepts instr this cycle
//   instr        out  registered instruction word
//   instr_valid  out  instr is offered
//   done         out  budget and drain complete
//   issued_count out  accepted handshakes so far (saturating)
// Revision    : 1.0 - initial release
// ============================================================================
module sodor5_instr_stim_gen
    import sodor5_stim_pkg::*;
#(
    parameter logic [31:0] SEED       = 32'h0000028E,
    parameter int          NUM_INSTRS = 100,
    parameter int          DRAIN_NOPS = 5,
    parameter bit          LOAD_EN    = 1'b0,
    parameter int          WORD_SIZE  = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 instr_ready,
    output logic [WORD_SIZE-1:0] instr,
    output logic                 instr_valid,
    output logic                 done,
    output logic [31:0]          issued_count
);

    localparam logic [31:0] SEED_EFF   = (SEED == 32'h0) ? 32'h1 : SEED;
    localparam logic [31:0] RUN_LAST   = 32'(NUM_INSTRS - 1);
    localparam logic [31:0] DRAIN_LAST = 32'(DRAIN_NOPS - 1);
    localparam logic [WORD_SIZE-1:0] NOP_W = WORD_SIZE'(NOP_INSTR);

    stim_state_t           state;
    stim_state_t           state_nxt;
    logic [WORD_SIZE-1:0]  instr_nxt;
    logic                  valid_nxt;
    logic                  done_nxt;
    logic [31:0]           phase_count;
    logic [31:0]           phase_count_nxt;
    logic [31:0]           lfsr_state;
    logic [31:0]           lfsr_next;
    logic                  lfsr_advance;
    logic                  xfer;

    sodor5_lfsr32 u_lfsr (
        .clk        (clk),
        .load_seed  (reset),
        .advance    (lfsr_advance),
        .seed       (SEED_EFF),
        .state      (lfsr_state),
        .next_state (lfsr_next)
    );

    assign xfer = instr_valid && instr_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            instr        <= NOP_W;
            instr_valid  <= 1'b0;
            done         <= 1'b0;
            issued_count <= '0;
            phase_count  <= '0;
        end else begin
            state        <= state_nxt;
            instr        <= instr_nxt;
            instr_valid  <= valid_nxt;
            done         <= done_nxt;
            phase_count  <= phase_count_nxt;
            if (xfer && (issued_count != 32'hFFFFFFFF)) begin
                issued_count <= issued_count + 32'd1;
            end
        end
    end

    // phase_count counts transfers within the current RUN or DRAIN phase.
    // valid follows en with one cycle of latency while words remain; the
    // offered word is only replaced on a transfer, so a pause holds it.
    always_comb begin
        state_nxt       = state;
        instr_nxt       = instr;
        valid_nxt       = instr_valid;
        done_nxt        = done;
        phase_count_nxt = phase_count;
        lfsr_advance    = 1'b0;

        case (state)
            IDLE: begin
                if (en) begin
                    phase_count_nxt = '0;
                    if (NUM_INSTRS != 0) begin
                        state_nxt = RUN;
                        instr_nxt = WORD_SIZE'(build_word(lfsr_state, LOAD_EN));
                        valid_nxt = 1'b1;
                    end else if (DRAIN_NOPS != 0) begin
                        state_nxt = DRAIN;
                        instr_nxt = NOP_W;
                        valid_nxt = 1'b1;
                    end else begin
                        state_nxt = DONE;
                        valid_nxt = 1'b0;
                        done_nxt  = 1'b1;
                    end
                end
            end

            RUN: begin
                valid_nxt = en;
                if (xfer) begin
                    lfsr_advance = 1'b1;
                    if (phase_count == RUN_LAST) begin
                        phase_count_nxt = '0;
                        instr_nxt       = NOP_W;
                        if (DRAIN_NOPS != 0) begin
                            state_nxt = DRAIN;
                        end else begin
                            state_nxt = DONE;
                            valid_nxt = 1'b0;
                            done_nxt  = 1'b1;
                        end
                    end else begin
                        phase_count_nxt = phase_count + 32'd1;
                        instr_nxt       = WORD_SIZE'(build_word(lfsr_next, LOAD_EN));
                    end
                end
            end

            DRAIN: begin
                valid_nxt = en;
                instr_nxt = NOP_W;
                if (xfer) begin
                    if (phase_count == DRAIN_LAST) begin
                        phase_count_nxt = '0;
                        state_nxt       = DONE;
                        valid_nxt       = 1'b0;
                        done_nxt        = 1'b1;
                    end else begin
                        phase_count_nxt = phase_count + 32'd1;
                    end
                end
            end

            DONE: begin
                instr_nxt = NOP_W;
                valid_nxt = 1'b0;
                done_nxt  = 1'b1;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_sodor5_instr_stim_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_sodor5_instr_stim_gen
// Description : Self-checking bench for sodor5_instr_stim_gen. Three
//               instances with different parameter sets share one clock.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sodor5_instr_stim_gen;

    localparam logic [31:0] NOP = 32'h00000013;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic en_a = 1'b0, rdy_a = 1'b0;
    logic en_b = 1'b0, rdy_b = 1'b0;
    logic en_c = 1'b0, rdy_c = 1'b0;

    logic [31:0] instr_a, instr_b, instr_c;
    logic        val_a, val_b, val_c;
    logic        done_a, done_b, done_c;
    logic [31:0] cnt_a, cnt_b, cnt_c;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    sodor5_instr_stim_gen #(
        .SEED(32'hFFF0D101), .NUM_INSTRS(20), .DRAIN_NOPS(2), .LOAD_EN(1'b1), .WORD_SIZE(32)
    ) dut_a (
        .clk(clk), .reset(reset), .en(en_a), .instr_ready(rdy_a),
        .instr(instr_a), .instr_valid(val_a), .done(done_a), .issued_count(cnt_a)
    );

    sodor5_instr_stim_gen #(
        .SEED(32'h0040C100), .NUM_INSTRS(3), .DRAIN_NOPS(2), .LOAD_EN(1'b1), .WORD_SIZE(32)
    ) dut_b (
        .clk(clk), .reset(reset), .en(en_b), .instr_ready(rdy_b),
        .instr(instr_b), .instr_valid(val_b), .done(done_b), .issued_count(cnt_b)
    );

    sodor5_instr_stim_gen #(
        .SEED(32'h0), .NUM_INSTRS(0), .DRAIN_NOPS(1), .LOAD_EN(1'b0), .WORD_SIZE(32)
    ) dut_c (
        .clk(clk), .reset(reset), .en(en_c), .instr_ready(rdy_c),
        .instr(instr_c), .instr_valid(val_c), .done(done_c), .issued_count(cnt_c)
    );

    // ---------------- reference model (arithmetic on the rules) ------------
    function automatic logic [31:0] m_step(input logic [31:0] l);
        if ((l % 2) == 1) return (l >> 1) ^ 32'h80200003;
        return l >> 1;
    endfunction

    function automatic logic [31:0] m_word(input logic [31:0] l, input bit ld);
        int unsigned imm, rs1, f3, rd;
        imm = (l >> 20) & 32'hFFF;
        rs1 = (l >> 15) & 32'h1F;
        f3  = (l >> 12) & 32'h7;
        rd  = (l >> 7)  & 32'h1F;
        if (ld && ((l % 4) == 0)) begin
            return (imm << 20) + (rs1 << 15) + (((f3 >= 4) ? 4 : 0) << 12) + (rd << 7) + 3;
        end
        if (f3 == 5) imm = imm & 32'h41F;
        if (f3 == 1) imm = imm & 32'h01F;
        return (imm << 20) + (rs1 << 15) + (f3 << 12) + (rd << 7) + 32'h13;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        bit en;
        bit rdy;
        bit exp_valid;
        bit exp_done;
        int exp_count;
        int word_idx;   // index into the model stream, -1 for NOP
    } vec_t;

    vec_t        tbl[9];
    logic [31:0] exp_a[$];
    logic [31:0] exp_b[$];

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] l;
        int          ptr;
        int          budget;
        bit          finished;
        bit          prev_en;
        bit          prev_hold;
        logic [31:0] prev_instr;
        logic [31:0] exp_w;

        // expected streams
        l = 32'hFFF0D101;
        for (int i = 0; i < 20; i++) begin
            exp_a.push_back(m_word(l, 1'b1));
            l = m_step(l);
        end
        exp_a.push_back(NOP);
        exp_a.push_back(NOP);
        l = 32'h0040C100;
        for (int i = 0; i < 3; i++) begin
            exp_b.push_back(m_word(l, 1'b1));
            l = m_step(l);
        end
        exp_b.push_back(NOP);
        exp_b.push_back(NOP);

        // en, rdy | valid, done, count, word
        tbl[0] = '{1, 1, 0, 0, 0, -1};
        tbl[1] = '{1, 0, 1, 0, 0,  0};
        tbl[2] = '{1, 1, 1, 0, 0,  0};
        tbl[3] = '{1, 1, 1, 0, 1,  1};
        tbl[4] = '{1, 1, 1, 0, 2,  2};
        tbl[5] = '{1, 1, 1, 0, 3,  3};
        tbl[6] = '{1, 1, 1, 0, 4,  4};
        tbl[7] = '{1, 1, 0, 1, 5, -1};
        tbl[8] = '{0, 0, 0, 1, 5, -1};

        // reset held for three cycles
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_instr", instr_a, NOP);
            chk("rst_valid", {31'b0, val_a}, 32'd0);
            chk("rst_done", {31'b0, done_a}, 32'd0);
            chk("rst_count", cnt_a, 32'd0);
        end
        reset = 1'b0;

        // table: NUM_INSTRS=3, DRAIN_NOPS=2 with a one-cycle stall
        for (int i = 0; i < 9; i++) begin
            exp_w = (tbl[i].word_idx < 0) ? NOP : exp_b[tbl[i].word_idx];
            chk($sformatf("b_valid[%0d]", i), {31'b0, val_b}, {31'b0, tbl[i].exp_valid});
            chk($sformatf("b_done[%0d]", i), {31'b0, done_b}, {31'b0, tbl[i].exp_done});
            chk($sformatf("b_count[%0d]", i), cnt_b, 32'(tbl[i].exp_count));
            chk($sformatf("b_instr[%0d]", i), instr_b, exp_w);
            if (i == 1) chk("b_first_lbu", instr_b, 32'h0040C103);
            en_b  = tbl[i].en;
            rdy_b = tbl[i].rdy;
            tick();
        end

        // NUM_INSTRS=0: straight into a single-NOP drain
        en_c = 1'b1;
        rdy_c = 1'b1;
        tick();
        chk("c_valid", {31'b0, val_c}, 32'd1);
        chk("c_nop", instr_c, NOP);
        tick();
        chk("c_done", {31'b0, done_c}, 32'd1);
        chk("c_valid_off", {31'b0, val_c}, 32'd0);
        chk("c_count", cnt_c, 32'd1);
        en_c = 1'b0;
        rdy_c = 1'b0;

        // SRAI word offered and held while not ready
        en_a = 1'b1;
        rdy_a = 1'b0;
        tick();
        chk("a_first_srai", instr_a, 32'h41F0D113);
        chk("a_first_valid", {31'b0, val_a}, 32'd1);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("a_hold_instr", instr_a, 32'h41F0D113);
            chk("a_hold_valid", {31'b0, val_a}, 32'd1);
        end
        chk("a_hold_count", cnt_a, 32'd0);

        // two transfers, then pause
        rdy_a = 1'b1;
        tick();
        tick();
        chk("a_two_count", cnt_a, 32'd2);
        chk("a_third_word", instr_a, exp_a[2]);
        en_a = 1'b0;
        rdy_a = 1'b0;
        tick();
        rdy_a = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("a_pause_valid", {31'b0, val_a}, 32'd0);
            chk("a_pause_count", cnt_a, 32'd2);
            chk("a_pause_instr", instr_a, exp_a[2]);
            tick();
        end
        en_a = 1'b1;
        tick();
        chk("a_resume_valid", {31'b0, val_a}, 32'd1);
        chk("a_resume_instr", instr_a, exp_a[2]);
        chk("a_resume_count", cnt_a, 32'd2);

        // reset mid-run restarts the sequence
        reset = 1'b1;
        tick();
        chk("a_rst_instr", instr_a, NOP);
        chk("a_rst_valid", {31'b0, val_a}, 32'd0);
        chk("a_rst_count", cnt_a, 32'd0);
        reset = 1'b0;
        rdy_a = 1'b0;
        tick();
        chk("a_restart_word", instr_a, 32'h41F0D113);
        chk("a_restart_valid", {31'b0, val_a}, 32'd1);

        // randomized en/ready run to completion against the model stream
        ptr = 0;
        budget = 0;
        finished = 1'b0;
        prev_en = 1'b1;
        prev_hold = 1'b0;
        prev_instr = instr_a;
        while (!finished && budget < 3000) begin
            chk("r_valid", {31'b0, val_a}, {31'b0, (prev_en && ptr < exp_a.size())});
            chk("r_done", {31'b0, done_a}, {31'b0, (ptr == exp_a.size())});
            chk("r_count", cnt_a, 32'(ptr));
            if (prev_hold) chk("r_stable", instr_a, prev_instr);
            if (ptr == exp_a.size()) begin
                finished = 1'b1;
            end else begin
                en_a  = ($urandom_range(0, 3) != 0);
                rdy_a = $urandom_range(0, 1) == 1;
                if (val_a && rdy_a) begin
                    chk($sformatf("r_word[%0d]", ptr), instr_a, exp_a[ptr]);
                    ptr++;
                end
                prev_hold  = val_a && !rdy_a;
                prev_instr = instr_a;
                prev_en    = en_a;
                tick();
                budget++;
            end
        end
        if (!finished) chk("r_timeout", 32'(ptr), 32'(exp_a.size()));
        chk("r_final_count", cnt_a, 32'd22);
        chk("r_final_instr", instr_a, NOP);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
